// File: rtl/multi_lane_data_bus_if.sv
// Bundle of control, transport and lane signals for multi_lane_data_bus.
// master = control FSM / transport / electrical side, slave = the bus block.
interface multi_lane_data_bus_if #(
  parameter int LANES  = 2,
  parameter int LANE_W = 8
);
  localparam int W = LANES * LANE_W;

  logic [3:0]   d_sel;
  logic         data_os;
  logic [W-1:0] transport_layer_data_in;
  logic [W-1:0] lane_rx;
  logic [W-1:0] lane_tx;
  logic         tx_lanes_on;
  logic         os_sent;
  logic [3:0]   os_in;
  logic [W-1:0] transport_layer_data_out;

  modport master (
    output d_sel, data_os, transport_layer_data_in, lane_rx,
    input  lane_tx, tx_lanes_on, os_sent, os_in, transport_layer_data_out
  );

  modport slave (
    input  d_sel, data_os, transport_layer_data_in, lane_rx,
    output lane_tx, tx_lanes_on, os_sent, os_in, transport_layer_data_out
  );
endinterface

// File: rtl/multi_lane_data_bus.sv
// LANES-wide logical-layer data bus: ordered-set burst sequencer (Tx) and symbol-run detector (Rx).
// Define DATA_BUS_LANE_CHECK_EN to require all lanes to agree before an OS is reported.
module multi_lane_data_bus #(
  parameter int LANES  = 2,
  parameter int LANE_W = 8,
  parameter int OS_LEN = 4
) (
  input logic                  fsm_clk,
  input logic                  rst,
  multi_lane_data_bus_if.slave bus
);
  localparam int W  = LANES * LANE_W;
  localparam int CW = $clog2(OS_LEN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(OS_LEN);
  localparam logic [CW-1:0] TX_LAST = CW'(OS_LEN - 1);
`ifdef DATA_BUS_LANE_CHECK_EN
  localparam int RX_LANES = LANES;
`else
  localparam int RX_LANES = 1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2,
    DATA = 2'd3
  } tx_state_t;

  function automatic logic [LANE_W-1:0] os_symbol(input logic [3:0] code);
    return {{(LANE_W-4){1'b1}}, code};
  endfunction

  // Only codes 1..4 are ordered sets; other all-ones-prefixed values count as data.
  function automatic logic is_os_symbol(input logic [LANE_W-1:0] sym);
    return (&sym[LANE_W-1:4]) && (sym[3:0] >= 4'd1) && (sym[3:0] <= 4'd4);
  endfunction

  tx_state_t                       state_r, state_s;
  logic [3:0]                      code_r, code_s;
  logic [CW-1:0]                   tx_cnt_r, tx_cnt_s;
  logic                            sel_valid_s;
  logic [W-1:0]                    lane_tx_r, lane_tx_s;
  logic                            tx_on_r, tx_on_s;
  logic                            os_sent_r, os_sent_s;

  logic [RX_LANES-1:0][LANE_W-1:0] prev_r;
  logic [RX_LANES-1:0][CW-1:0]     run_r, run_s;
  logic                            hit_s;
  logic [3:0]                      os_in_r, os_in_s;
  logic [W-1:0]                    rx_out_r, rx_out_s;

  // Tx next-state: OS requests win over data mode and are ignored while a burst runs
  always_comb begin
    state_s     = state_r;
    code_s      = code_r;
    tx_cnt_s    = tx_cnt_r;
    sel_valid_s = (bus.d_sel >= 4'd1) && (bus.d_sel <= 4'd4);
    case (state_r)
      IDLE, DATA: begin
        if (sel_valid_s) begin
          state_s  = SEND;
          code_s   = bus.d_sel;
          tx_cnt_s = '0;
        end else if (bus.data_os) begin
          state_s = DATA;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (tx_cnt_r == TX_LAST) begin
          state_s = DONE;
        end else begin
          tx_cnt_s = tx_cnt_r + 1'b1;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Tx outputs follow the current state so the first symbol lands one cycle after the request
  always_comb begin
    lane_tx_s = '0;
    tx_on_s   = 1'b0;
    os_sent_s = 1'b0;
    case (state_r)
      SEND: begin
        lane_tx_s = {LANES{os_symbol(code_r)}};
        tx_on_s   = 1'b1;
      end
      DONE: begin
        tx_on_s   = 1'b1;
        os_sent_s = 1'b1;
      end
      DATA: begin
        lane_tx_s = bus.transport_layer_data_in;
        tx_on_s   = 1'b1;
      end
      IDLE:    lane_tx_s = '0;
      default: lane_tx_s = '0;
    endcase
  end

  // Rx run counters per lane; a hit needs every built counter saturated on the lane-0 code
  always_comb begin
    run_s = run_r;
    hit_s = 1'b1;
    for (int k = 0; k < RX_LANES; k++) begin
      if (bus.data_os) begin
        run_s[k] = '0;
      end else if (!is_os_symbol(bus.lane_rx[k*LANE_W +: LANE_W])) begin
        run_s[k] = '0;
      end else if (bus.lane_rx[k*LANE_W +: LANE_W] != prev_r[k]) begin
        run_s[k] = {{(CW-1){1'b0}}, 1'b1};
      end else if (run_r[k] == RUN_MAX) begin
        run_s[k] = RUN_MAX;
      end else begin
        run_s[k] = run_r[k] + 1'b1;
      end
      hit_s = hit_s & (run_s[k] == RUN_MAX) &
              (bus.lane_rx[k*LANE_W +: 4] == bus.lane_rx[3:0]);
    end
    if (bus.data_os) begin
      os_in_s = 4'd0;
    end else if (hit_s) begin
      os_in_s = bus.lane_rx[3:0];
    end else begin
      os_in_s = os_in_r;
    end
    if (bus.data_os) begin
      rx_out_s = bus.lane_rx;
    end else begin
      rx_out_s = '0;
    end
  end

  // State and registered outputs
  always_ff @(posedge fsm_clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      code_r    <= 4'd0;
      tx_cnt_r  <= '0;
      lane_tx_r <= '0;
      tx_on_r   <= 1'b0;
      os_sent_r <= 1'b0;
      prev_r    <= '0;
      run_r     <= '0;
      os_in_r   <= 4'd0;
      rx_out_r  <= '0;
    end else begin
      state_r   <= state_s;
      code_r    <= code_s;
      tx_cnt_r  <= tx_cnt_s;
      lane_tx_r <= lane_tx_s;
      tx_on_r   <= tx_on_s;
      os_sent_r <= os_sent_s;
      prev_r    <= bus.lane_rx[RX_LANES*LANE_W-1:0];
      run_r     <= run_s;
      os_in_r   <= os_in_s;
      rx_out_r  <= rx_out_s;
    end
  end

  assign bus.lane_tx                  = lane_tx_r;
  assign bus.tx_lanes_on              = tx_on_r;
  assign bus.os_sent                  = os_sent_r;
  assign bus.os_in                    = os_in_r;
  assign bus.transport_layer_data_out = rx_out_r;
endmodule

// File: tb/tb_multi_lane_data_bus.sv
// Scoreboard bench for multi_lane_data_bus: directed test-plan sequences followed by random traffic.
module tb_multi_lane_data_bus;
  localparam int LANES  = 2;
  localparam int LANE_W = 8;
  localparam int OS_LEN = 4;
  localparam int W      = LANES * LANE_W;
`ifdef DATA_BUS_LANE_CHECK_EN
  localparam int CHK_LANES = LANES;
`else
  localparam int CHK_LANES = 1;
`endif

  logic fsm_clk = 1'b0;
  logic rst     = 1'b0;

  multi_lane_data_bus_if #(.LANES(LANES), .LANE_W(LANE_W)) bus ();

  multi_lane_data_bus #(.LANES(LANES), .LANE_W(LANE_W), .OS_LEN(OS_LEN)) dut (
    .fsm_clk (fsm_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 fsm_clk = ~fsm_clk;

  typedef struct packed {
    logic [W-1:0] tx;
    logic         on;
    logic         sent;
    logic [3:0]   osin;
    logic [W-1:0] rxo;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;

  // reference model: timeline of the current burst plus raw Rx history since last clear
  int           edge_n      = 0;
  int           burst_start = -1000;
  logic [3:0]   burst_code  = 4'd0;
  bit           data_mode   = 1'b0;
  logic [3:0]   os_in_m     = 4'd0;
  logic [W-1:0] rx_hist[$];

  int           hold, dhold;
  logic [3:0]   dsel_v, rc;
  bit           dos_v;
  logic [W-1:0] rxw;

  function automatic logic [LANE_W-1:0] sym(input logic [3:0] c);
    return {4'hF, c};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual %h required %h", name, $time, act, req);
    end
  endtask

  function automatic bit run_hit(output logic [3:0] c);
    int n;
    logic [W-1:0] w;
    n = rx_hist.size();
    c = 4'd0;
    if (n < OS_LEN) return 1'b0;
    w = rx_hist[n-1];
    c = w[3:0];
    if (c < 4'd1 || c > 4'd4) return 1'b0;
    for (int i = n - OS_LEN; i < n; i++) begin
      w = rx_hist[i];
      for (int k = 0; k < CHK_LANES; k++)
        if (w[k*LANE_W +: LANE_W] != sym(c)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    burst_start = -1000;
    data_mode   = 1'b0;
    os_in_m     = 4'd0;
    rx_hist.delete();
  endtask

  // one rising edge of the reference model with the inputs present at that edge
  task automatic model_edge(input logic [3:0] dsel, input bit dos, input logic [W-1:0] tdi,
                            input logic [W-1:0] rx, output exp_t e);
    int off;
    logic [3:0] c;
    e   = '0;
    off = edge_n - burst_start;
    if (off >= 1 && off <= OS_LEN) begin
      e.tx = {LANES{sym(burst_code)}};
      e.on = 1'b1;
    end else if (off == OS_LEN + 1) begin
      e.on   = 1'b1;
      e.sent = 1'b1;
    end else begin
      if (data_mode) begin
        e.tx = tdi;
        e.on = 1'b1;
      end
      if (dsel >= 4'd1 && dsel <= 4'd4) begin
        burst_start = edge_n;
        burst_code  = dsel;
        data_mode   = 1'b0;
      end else begin
        data_mode = dos;
      end
    end
    if (dos) begin
      rx_hist.delete();
      os_in_m = 4'd0;
    end else begin
      rx_hist.push_back(rx);
      if (run_hit(c)) os_in_m = c;
    end
    e.osin = os_in_m;
    e.rxo  = dos ? rx : '0;
    edge_n++;
  endtask

  task automatic apply_now(input logic [3:0] dsel, input bit dos, input logic [W-1:0] tdi,
                           input logic [W-1:0] rx);
    exp_t e;
    bus.d_sel                   = dsel;
    bus.data_os                 = dos;
    bus.transport_layer_data_in = tdi;
    bus.lane_rx                 = rx;
    if (!rst) e = '0;
    else model_edge(dsel, dos, tdi, rx, e);
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] dsel, input bit dos, input logic [W-1:0] tdi,
                       input logic [W-1:0] rx);
    @(negedge fsm_clk);
    apply_now(dsel, dos, tdi, rx);
  endtask

  task automatic do_reset(input int n);
    @(negedge fsm_clk);
    rst = 1'b0;
    #1;
    chk("rst_lane_tx", bus.lane_tx, '0);
    chk("rst_tx_on", W'(bus.tx_lanes_on), '0);
    chk("rst_os_sent", W'(bus.os_sent), '0);
    chk("rst_os_in", W'(bus.os_in), '0);
    chk("rst_rx_out", bus.transport_layer_data_out, '0);
    model_reset();
    for (int i = 0; i < n; i++)
      drive(4'($urandom), 1'($urandom), W'($urandom), W'($urandom));
    @(negedge fsm_clk);
    rst = 1'b1;
    apply_now(4'd0, 1'b0, '0, '0);
  endtask

  // monitor: every edge the DUT presents a full output set, compared against the oldest prediction
  initial begin
    forever begin
      @(posedge fsm_clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("lane_tx", bus.lane_tx, mon_e.tx);
        chk("tx_lanes_on", W'(bus.tx_lanes_on), W'(mon_e.on));
        chk("os_sent", W'(bus.os_sent), W'(mon_e.sent));
        chk("os_in", W'(bus.os_in), W'(mon_e.osin));
        chk("rx_data_out", bus.transport_layer_data_out, mon_e.rxo);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, actual running required finished");
    $fatal(1);
  end

  initial begin
    bus.d_sel                   = 4'd0;
    bus.data_os                 = 1'b0;
    bus.transport_layer_data_in = '0;
    bus.lane_rx                 = '0;
    do_reset(3);

    // TS1 burst
    drive(4'd3, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) drive(4'd0, 1'b0, '0, '0);

    // data mode, then SLOS1 preempting data, then back to data
    for (int i = 0; i < 3; i++) drive(4'd0, 1'b1, 16'hA55A, '0);
    drive(4'd1, 1'b1, 16'hA55A, '0);
    for (int i = 0; i < 8; i++) drive(4'd0, 1'b1, 16'h1234, '0);
    for (int i = 0; i < 2; i++) drive(4'd0, 1'b0, '0, '0);

    // Rx SLOS2 full run, then a short run after a clear
    for (int i = 0; i < 4; i++) drive(4'd0, 1'b0, '0, 16'hF2F2);
    for (int i = 0; i < 2; i++) drive(4'd0, 1'b0, '0, 16'h0012);
    drive(4'd0, 1'b1, '0, 16'h5A5A);
    for (int i = 0; i < 3; i++) drive(4'd0, 1'b0, '0, 16'hF2F2);
    for (int i = 0; i < 2; i++) drive(4'd0, 1'b0, '0, 16'h0012);

    // lane disagreement: lane 0 = TS2, lane 1 = TS1
    for (int i = 0; i < 4; i++) drive(4'd0, 1'b0, '0, 16'hF3F4);
    drive(4'd0, 1'b0, '0, 16'h0000);

    // reset during the second burst symbol, then a clean burst
    drive(4'd3, 1'b0, '0, '0);
    drive(4'd0, 1'b0, '0, '0);
    drive(4'd0, 1'b0, '0, '0);
    do_reset(2);
    drive(4'd2, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) drive(4'd0, 1'b0, '0, '0);

    // random traffic
    hold   = 0;
    dhold  = 0;
    dsel_v = 4'd0;
    dos_v  = 1'b0;
    rxw    = '0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 6);
        case ($urandom_range(0, 3))
          0: for (int k = 0; k < LANES; k++)
               rxw[k*LANE_W +: LANE_W] = {1'b0, (LANE_W-1)'($urandom)};
          1, 2: begin
            rc  = 4'($urandom_range(1, 4));
            rxw = {LANES{sym(rc)}};
          end
          default: for (int k = 0; k < LANES; k++)
                     rxw[k*LANE_W +: LANE_W] = sym(4'($urandom_range(1, 4)));
        endcase
      end
      hold--;
      if (dhold == 0) begin
        dsel_v = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        dhold  = $urandom_range(1, 5);
      end
      dhold--;
      if ($urandom_range(0, 15) == 0) dos_v = ~dos_v;
      drive(dsel_v, dos_v, W'($urandom), rxw);
    end
    for (int i = 0; i < 3; i++) drive(4'd0, 1'b0, '0, '0);
    @(posedge fsm_clk);
    #2;
    chk("scoreboard_drained", W'(sb_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
